// File: rtl/jk_arb_pkg.sv
// ============================================================================
// Module      : jk_arb_pkg
// Description : Shared FSM state type, JK command encodings and the JK
//               next-state function for the JK bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } jk_state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_arb_picker.sv
// ============================================================================
// Module      : jk_arb_picker
// Description : Combinational winner select. Round-robin from rr_ptr by
//               default; fixed lowest-index priority when JK_ARB_PRIO_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_arb_picker
  import jk_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] rr_ptr,
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [PTRW-1:0] idx
);

  int w_cand;

`ifdef JK_ARB_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^rr_ptr;
`endif

  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    w_cand = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef JK_ARB_PRIO_EN
      w_cand = i;
`else
      w_cand = (int'(rr_ptr) + i) % NREQ;
`endif
      if (!valid && req[w_cand]) begin
        valid          = 1'b1;
        onehot[w_cand] = 1'b1;
        idx            = PTRW'(w_cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
// ============================================================================
// Module      : jk_bank_arbiter
// Description : Arbitrates NREQ requesters onto one bank of WIDTH JK flops,
//               IDLE -> APPLY -> ACK per command. Macro JK_ARB_PRIO_EN
//               selects fixed priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_j,
  input  logic [NREQ-1:0]      req_k,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [WIDTH-1:0]     q
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  jk_state_t       r_state;
  logic [PTRW-1:0] r_win;
  logic [PTRW-1:0] r_rr_ptr;
  logic            r_j;
  logic            r_k;
  logic [IDXW-1:0] r_idx;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_ack;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  logic            w_pick_valid;
  logic [NREQ-1:0] w_pick_onehot;
  logic [PTRW-1:0] w_pick_idx;

  jk_arb_picker #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_picker (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_pick_valid),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx)
  );

  // Out-of-range indices (non power-of-2 WIDTH) leave the bank untouched.
  always_comb begin
    w_q_next = r_q;
    if (int'(r_idx) < WIDTH) begin
      w_q_next[r_idx] = jk_next(r_q[r_idx], r_j, r_k);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_win    <= '0;
      r_rr_ptr <= '0;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_idx    <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_q      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_win   <= w_pick_idx;
            r_j     <= req_j[w_pick_idx];
            r_k     <= req_k[w_pick_idx];
            r_idx   <= req_idx[int'(w_pick_idx)*IDXW +: IDXW];
            r_gnt   <= w_pick_onehot;
            r_state <= APPLY;
          end
        end
        APPLY: begin
          r_q     <= w_q_next;
          r_gnt   <= '0;
          r_ack   <= r_gnt;
          r_state <= ACK;
        end
        ACK: begin
          r_ack    <= '0;
          r_rr_ptr <= (r_win == PTRW'(NREQ - 1)) ? '0 : r_win + 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign busy = (r_state != IDLE);
  assign q    = r_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
// ============================================================================
// Module      : tb_jk_bank_arbiter
// Description : Scoreboard bench for jk_bank_arbiter (WIDTH=8 and WIDTH=6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_bank_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req, req_j, req_k;
  logic [11:0] req_idx;
  logic [3:0]  gnt, ack;
  logic        busy;
  logic [7:0]  q;

  logic [3:0]  req6, req6_j, req6_k;
  logic [11:0] req6_idx;
  logic [3:0]  gnt6, ack6;
  logic        busy6;
  logic [5:0]  q6;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] q;
  } exp_t;

  logic [3:0] exp_gnt[$];
  exp_t       exp_ack[$];

  int n_pass  = 0;
  int n_total = 0;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clock(clock), .reset(reset), .req(req), .req_j(req_j), .req_k(req_k),
    .req_idx(req_idx), .gnt(gnt), .ack(ack), .busy(busy), .q(q)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6)) dut6 (
    .clock(clock), .reset(reset), .req(req6), .req_j(req6_j), .req_k(req6_k),
    .req_idx(req6_idx), .gnt(gnt6), .ack(ack6), .busy(busy6), .q(q6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Monitor: every grant and ack the DUT presents is matched against the queues.
  always @(negedge clock) begin
    if (gnt !== 4'b0) begin
      if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 32'h0);
      else check("sb_gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
    end
    if (ack !== 4'b0) begin
      if (exp_ack.size() == 0) check("ack_unexpected", 32'(ack), 32'h0);
      else begin
        exp_t e;
        e = exp_ack.pop_front();
        check("sb_ack", 32'(ack), 32'(e.ack));
        check("sb_q_at_ack", 32'(q), 32'(e.q));
      end
    end
  end

  task automatic expect_cmd(input int r, input logic [7:0] qexp);
    exp_t e;
    e.ack = 4'(1 << r);
    e.q   = qexp;
    exp_gnt.push_back(4'(1 << r));
    exp_ack.push_back(e);
  endtask

  task automatic wait_ack(output logic [3:0] seen);
    seen = 4'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1;
      if (ack != 4'b0) begin
        seen = ack;
        break;
      end
    end
    if (seen == 4'b0) check("ack_timeout", 32'(ack != 4'b0), 32'h1);
  endtask

  task automatic issue(input int r, input logic j, input logic k,
                       input logic [2:0] idx, input logic [7:0] qexp);
    logic [3:0] seen;
    expect_cmd(r, qexp);
    req[r]            = 1'b1;
    req_j[r]          = j;
    req_k[r]          = k;
    req_idx[r*3 +: 3] = idx;
    wait_ack(seen);
    req[r] = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int         order[$];
    logic [7:0] qacc;
    logic [3:0] seen;
    bit         kept0;

    reset = 1'b0; req = '0; req_j = '0; req_k = '0; req_idx = '0;
    req6 = '0; req6_j = '0; req6_k = '0; req6_idx = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Test 1: preload 0xFF, then reset for 2 edges
    qacc = 8'h00;
    for (int b = 0; b < 8; b++) begin
      qacc[b] = 1'b1;
      issue(b % 4, 1'b1, 1'b0, 3'(b), qacc);
    end
    check("preload_q", 32'(q), 32'hFF);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_q", 32'(q), 32'h00);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_q6", 32'(q6), 32'h00);
    reset = 1'b1;

    // Test 2: single set with cycle-exact timing
    expect_cmd(0, 8'h08);
    req[0] = 1'b1; req_j[0] = 1'b1; req_k[0] = 1'b0; req_idx[2:0] = 3'd3;
    @(posedge clock); #1;
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_busy", 32'(busy), 32'h1);
    check("t2_q_pre", 32'(q), 32'h00);
    @(posedge clock); #1;
    check("t2_gnt_drop", 32'(gnt), 32'h0);
    check("t2_ack", 32'(ack), 32'h1);
    check("t2_q", 32'(q), 32'h08);
    req[0] = 1'b0;
    @(posedge clock); #1;
    check("t2_ack_drop", 32'(ack), 32'h0);
    check("t2_busy_low", 32'(busy), 32'h0);

    // Test 3: encodings on bit 5 (clear bit 3 first)
    issue(1, 1'b0, 1'b1, 3'd3, 8'h00);
    issue(1, 1'b1, 1'b1, 3'd5, 8'h20);
    issue(2, 1'b1, 1'b1, 3'd5, 8'h00);
    issue(3, 1'b1, 1'b0, 3'd5, 8'h20);
    issue(0, 1'b0, 1'b0, 3'd5, 8'h20);
    issue(1, 1'b0, 1'b1, 3'd5, 8'h00);

    // Test 4: all four held, each drops after its own ack
    do_reset();
`ifdef JK_ARB_PRIO_EN
    order = '{0, 0, 1, 2, 3};
`else
    order = '{0, 1, 2, 3};
`endif
    qacc = 8'h00;
    foreach (order[i]) begin
      qacc[order[i]] = 1'b1;
      expect_cmd(order[i], qacc);
    end
    req_j = 4'b1111; req_k = 4'b0000; req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    kept0 = 1'b0;
    foreach (order[n]) begin
      wait_ack(seen);
      for (int b = 0; b < 4; b++) begin
        if (seen[b]) begin
`ifdef JK_ARB_PRIO_EN
          if (b == 0 && !kept0) kept0 = 1'b1;
          else req[b] = 1'b0;
`else
          req[b] = 1'b0;
`endif
        end
      end
    end
    req = 4'b0;
    @(posedge clock); #1;
    check("t4_q", 32'(q), 32'h0F);

    // Test 5: reset lands in the APPLY cycle
    do_reset();
    exp_gnt.push_back(4'b0100);
    req[2] = 1'b1; req_j[2] = 1'b1; req_k[2] = 1'b0; req_idx[8:6] = 3'd2;
    @(posedge clock); #1;
    check("t5_gnt", 32'(gnt), 32'h4);
    reset = 1'b0; req[2] = 1'b0;
    @(posedge clock); #1;
    check("t5_q", 32'(q), 32'h00);
    check("t5_ack", 32'(ack), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("t5_no_ack_later", 32'(ack), 32'h0);
    check("t5_q_later", 32'(q), 32'h00);

    // Test 6: WIDTH=6, out-of-range idx behaves as hold
    req6[0] = 1'b1; req6_j[0] = 1'b1; req6_k[0] = 1'b0; req6_idx[2:0] = 3'd1;
    @(posedge clock); #1;
    check("t6_gnt_a", 32'(gnt6), 32'h1);
    @(posedge clock); #1;
    check("t6_ack_a", 32'(ack6), 32'h1);
    check("t6_q_a", 32'(q6), 32'h02);
    req6[0] = 1'b0;
    @(posedge clock); #1;
    req6[0] = 1'b1; req6_j[0] = 1'b1; req6_k[0] = 1'b1; req6_idx[2:0] = 3'd7;
    @(posedge clock); #1;
    check("t6_gnt_b", 32'(gnt6), 32'h1);
    @(posedge clock); #1;
    check("t6_ack_b", 32'(ack6), 32'h1);
    check("t6_q_b", 32'(q6), 32'h02);
    req6[0] = 1'b0;
    @(posedge clock); #1;
    check("t6_busy_low", 32'(busy6), 32'h0);

    repeat (4) @(posedge clock);
    #1;
    check("sb_gnt_drained", 32'(exp_gnt.size()), 32'h0);
    check("sb_ack_drained", 32'(exp_ack.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
